// File: rtl/prbs17_checker.sv
// Serial checker for the x^17 + x^14 + 1 PRBS stream. It self-synchronises, verifies, and then locks.
// Once locked it counts bit errors and drops lock when errors in one window reach UNLOCK_THR.
module prbs17_checker #(
    parameter int LOCK_CNT   = 32,
    parameter int WIN        = 64,
    parameter int UNLOCK_THR = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bit_in,
    input  logic             clear,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [1:0]       state
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN + 1);
    localparam int WERR_W  = $clog2(UNLOCK_THR + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [16:0]        r_q, r_d;
    logic [4:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic               locked_q, locked_d;
    logic               bit_err_q, bit_err_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   bcnt_q, bcnt_d;

    logic               pred_s;
    logic               mismatch_s;
    logic [16:0]        shift_s;
    logic               inc_err_s;
    logic               inc_bit_s;
    logic [WIN_W-1:0]   win_n_s;
    logic [WERR_W-1:0]  werr_n_s;

    // r_q[k-1] holds the bit received k enabled cycles ago.
    assign pred_s     = r_q[13] ^ r_q[16];
    assign mismatch_s = bit_in ^ pred_s;
    assign shift_s    = {r_q[15:0], bit_in};

    // Next-state logic for the sync FSM, predictor, window and statistics counters.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        fill_d    = fill_q;
        match_d   = match_q;
        win_d     = win_q;
        werr_d    = werr_q;
        locked_d  = locked_q;
        bit_err_d = 1'b0;
        err_d     = err_q;
        bcnt_d    = bcnt_q;
        inc_err_s = 1'b0;
        inc_bit_s = 1'b0;
        win_n_s   = win_q + {{(WIN_W-1){1'b0}}, 1'b1};
        werr_n_s  = werr_q + {{(WERR_W-1){1'b0}}, mismatch_s};

        if (en) begin
            case (state_q)
                ST_SEARCH: begin
                    r_d = shift_s;
                    if (fill_q == 5'd16) begin
                        fill_d = 5'd0;
                        // An all-zero register would predict zeros forever; keep searching.
                        if (shift_s == 17'd0) begin
                            state_d = ST_SEARCH;
                        end else begin
                            state_d = ST_VERIFY;
                            match_d = {MATCH_W{1'b0}};
                        end
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                ST_VERIFY: begin
                    r_d = shift_s;
                    if (mismatch_s) begin
                        state_d = ST_SEARCH;
                        fill_d  = 5'd0;
                    end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        match_d  = {MATCH_W{1'b0}};
                        win_d    = {WIN_W{1'b0}};
                        werr_d   = {WERR_W{1'b0}};
                    end else begin
                        match_d = match_q + {{(MATCH_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_LOCKED: begin
                    // Feed back the prediction so a corrupted bit never pollutes the predictor.
                    r_d       = {r_q[15:0], pred_s};
                    inc_bit_s = 1'b1;
                    inc_err_s = mismatch_s;
                    bit_err_d = mismatch_s;
                    if (werr_n_s == WERR_W'(UNLOCK_THR)) begin
                        state_d  = ST_SEARCH;
                        locked_d = 1'b0;
                        fill_d   = 5'd0;
                        win_d    = {WIN_W{1'b0}};
                        werr_d   = {WERR_W{1'b0}};
                    end else if (win_n_s == WIN_W'(WIN)) begin
                        win_d  = {WIN_W{1'b0}};
                        werr_d = {WERR_W{1'b0}};
                    end else begin
                        win_d  = win_n_s;
                        werr_d = werr_n_s;
                    end
                end
                default: begin
                    state_d  = ST_SEARCH;
                    locked_d = 1'b0;
                    fill_d   = 5'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (clear) begin
            err_d  = {CNT_W{1'b0}};
            bcnt_d = {CNT_W{1'b0}};
        end else begin
            if (inc_err_s && (err_q != CNT_MAX)) begin
                err_d = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_d = err_q;
            end
            if (inc_bit_s && (bcnt_q != CNT_MAX)) begin
                bcnt_d = bcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                bcnt_d = bcnt_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            r_q       <= 17'd0;
            fill_q    <= 5'd0;
            match_q   <= {MATCH_W{1'b0}};
            win_q     <= {WIN_W{1'b0}};
            werr_q    <= {WERR_W{1'b0}};
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
            err_q     <= {CNT_W{1'b0}};
            bcnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_q     <= win_d;
            werr_q    <= werr_d;
            locked_q  <= locked_d;
            bit_err_q <= bit_err_d;
            err_q     <= err_d;
            bcnt_q    <= bcnt_d;
        end
    end

    assign state   = state_q;
    assign locked  = locked_q;
    assign bit_err = bit_err_q;
    assign err_cnt = err_q;
    assign bit_cnt = bcnt_q;

endmodule

// File: tb/tb_prbs17_checker.sv
// Scoreboard bench for prbs17_checker: a reference x^17 + x^14 + 1 generator drives the stream.
// Expected locked/bit_err values are queued per driven bit and checked after each clock edge.
module tb_prbs17_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        bit_in = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        bit_err;
    logic [15:0] err_cnt;
    logic [15:0] bit_cnt;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    logic [16:0] gen_q;

    typedef struct packed {
        logic lk;
        logic be;
    } exp_t;

    exp_t sbq[$];

    prbs17_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .bit_in  (bit_in),
        .clear   (clear),
        .locked  (locked),
        .bit_err (bit_err),
        .err_cnt (err_cnt),
        .bit_cnt (bit_cnt),
        .state   (state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference generator: gen_q[k-1] is Q[k]; the output is Q[17].
    task automatic gen_bit(output logic b);
        b     = gen_q[16];
        gen_q = {gen_q[15:0], gen_q[13] ^ gen_q[16]};
    endtask

    task automatic step(input logic e, input logic b, input logic c);
        @(negedge clk);
        en     = e;
        bit_in = b;
        clear  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en     = 1'b0;
        bit_in = 1'b0;
        clear  = 1'b0;
        rst_n  = 1'b0;
        #3;
        rst_n  = 1'b1;
        sbq.delete();
        gen_q  = 17'h00001;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        total++;
        if ({locked, bit_err, err_cnt, bit_cnt, state} !== 35'd0) begin
            bad++;
            $display("FAIL reset: got lk=%b be=%b err=%0d bits=%0d st=%0d want all zero",
                     locked, bit_err, err_cnt, bit_cnt, state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean();
        logic b;
        exp_t ex;
        do_reset();
        for (int n = 1; n <= 1000; n++) begin
            gen_bit(b);
            sbq.push_back('{lk: (n >= 49), be: 1'b0});
            step(1'b1, b, 1'b0);
            ex = sbq.pop_front();
            total++;
            if (locked !== ex.lk || bit_err !== ex.be) begin
                bad++;
                $display("FAIL clean n=%0d: lk/be got %b%b want %b%b", n, locked, bit_err, ex.lk, ex.be);
            end
            if (n == 16 || n == 17) begin
                total++;
                if (state !== ((n == 17) ? 2'd1 : 2'd0)) begin
                    bad++;
                    $display("FAIL clean_state n=%0d: got %0d want %0d", n, state, (n == 17) ? 1 : 0);
                end
            end
        end
        total++;
        if (err_cnt !== 16'd0 || bit_cnt !== 16'd951) begin
            bad++;
            $display("FAIL clean_counts: err=%0d bits=%0d want 0 951", err_cnt, bit_cnt);
        end
    endtask

    task automatic test_single_err();
        logic b;
        exp_t ex;
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            gen_bit(b);
            sbq.push_back('{lk: (n >= 49), be: (n == 200)});
            step(1'b1, b ^ (n == 200), 1'b0);
            ex = sbq.pop_front();
            total++;
            if (locked !== ex.lk || bit_err !== ex.be) begin
                bad++;
                $display("FAIL single_err n=%0d: lk/be got %b%b want %b%b", n, locked, bit_err, ex.lk, ex.be);
            end
        end
        total++;
        if (err_cnt !== 16'd1 || bit_cnt !== 16'd251 || locked !== 1'b1) begin
            bad++;
            $display("FAIL single_err_counts: err=%0d bits=%0d lk=%b want 1 251 1", err_cnt, bit_cnt, locked);
        end
    endtask

    task automatic test_unlock();
        logic b;
        logic inj;
        exp_t ex;
        do_reset();
        for (int n = 1; n <= 170; n++) begin
            gen_bit(b);
            inj = (n >= 50) && (n <= 106) && (((n - 50) % 8) == 0);
            sbq.push_back('{lk: ((n >= 49 && n < 106) || n >= 155), be: inj});
            step(1'b1, b ^ inj, 1'b0);
            ex = sbq.pop_front();
            total++;
            if (locked !== ex.lk || bit_err !== ex.be) begin
                bad++;
                $display("FAIL unlock n=%0d: lk/be got %b%b want %b%b", n, locked, bit_err, ex.lk, ex.be);
            end
            if (n == 106) begin
                total++;
                if (err_cnt !== 16'd8 || state !== 2'd0) begin
                    bad++;
                    $display("FAIL unlock_drop: err=%0d st=%0d want 8 0", err_cnt, state);
                end
            end
        end
        total++;
        if (err_cnt !== 16'd8 || state !== 2'd2) begin
            bad++;
            $display("FAIL unlock_relock: err=%0d st=%0d want 8 2", err_cnt, state);
        end
    endtask

    task automatic test_zero();
        exp_t ex;
        do_reset();
        for (int n = 1; n <= 200; n++) begin
            sbq.push_back('{lk: 1'b0, be: 1'b0});
            step(1'b1, 1'b0, 1'b0);
            ex = sbq.pop_front();
            total++;
            if (locked !== ex.lk || bit_err !== ex.be || state !== 2'd0) begin
                bad++;
                $display("FAIL zero n=%0d: lk/be/st got %b%b%0d want %b%b0", n, locked, bit_err, state, ex.lk, ex.be);
            end
        end
    endtask

    task automatic test_en_toggle();
        logic b;
        logic e;
        int k;
        exp_t ex;
        logic [15:0] exp_bits;
        do_reset();
        k = 0;
        for (int c = 0; c < 400 && k < 60; c++) begin
            e = ((c % 4) == 0) || ((c % 4) == 3);
            if (e) begin
                gen_bit(b);
                k++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            exp_bits = (k >= 49) ? 16'(k - 49) : 16'd0;
            sbq.push_back('{lk: (k >= 49), be: 1'b0});
            step(e, b, 1'b0);
            ex = sbq.pop_front();
            total++;
            if (locked !== ex.lk || bit_err !== ex.be || bit_cnt !== exp_bits) begin
                bad++;
                $display("FAIL en_toggle c=%0d k=%0d: lk/be/bits got %b%b%0d want %b%b%0d",
                         c, k, locked, bit_err, bit_cnt, ex.lk, ex.be, exp_bits);
            end
        end
        total++;
        if (k != 60) begin
            bad++;
            $display("FAIL en_toggle_budget: enabled bits got %0d want 60", k);
        end
    endtask

    task automatic test_clear_err();
        logic b;
        logic inj;
        exp_t ex;
        do_reset();
        for (int n = 1; n <= 82; n++) begin
            gen_bit(b);
            inj = (n == 55) || (n == 60) || (n == 65) || (n == 70) || (n == 75) || (n == 80) || (n == 82);
            sbq.push_back('{lk: (n >= 49), be: inj});
            step(1'b1, b ^ inj, (n == 80));
            ex = sbq.pop_front();
            total++;
            if (locked !== ex.lk || bit_err !== ex.be) begin
                bad++;
                $display("FAIL clear_err n=%0d: lk/be got %b%b want %b%b", n, locked, bit_err, ex.lk, ex.be);
            end
            if (n == 75 || n == 80 || n == 82) begin
                total++;
                if (err_cnt !== ((n == 75) ? 16'd5 : (n == 80) ? 16'd0 : 16'd1)) begin
                    bad++;
                    $display("FAIL clear_err_cnt n=%0d: err=%0d want %0d", n, err_cnt,
                             (n == 75) ? 5 : (n == 80) ? 0 : 1);
                end
            end
        end
        total++;
        if (bit_cnt !== 16'd2) begin
            bad++;
            $display("FAIL clear_bits: bits=%0d want 2", bit_cnt);
        end
        @(negedge clk);
        en    = 1'b0;
        clear = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (locked !== 1'b0 || err_cnt !== 16'd0 || state !== 2'd0 || bit_err !== 1'b0 || bit_cnt !== 16'd0) begin
            bad++;
            $display("FAIL async_reset: lk=%b err=%0d st=%0d be=%b bits=%0d want all zero",
                     locked, err_cnt, state, bit_err, bit_cnt);
        end
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_err();
        test_unlock();
        test_zero();
        test_en_toggle();
        test_clear_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
